lsu: RTL

Load/store initiator for the data memory port in the RV32I core. It accepts one memory request at a time from the MEM stage over a valid/ready handshake and decodes funct3 into byte enables, lane-replicated write data and a word-aligned address. It drives the memory for a single access cycle, waits a configurable read latency, then sign- or zero-extends the returned lane and reports the result. Misaligned and illegal requests are trapped as faults, and the memory is not touched for them.

---
 rtl/lsu_if.sv | 31 +++
 rtl/lsu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Request/response and data-memory signal bundle between the MEM stage, the lsu and the data memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    logic        mem_we;
    logic [3:0]  mem_byteEnable;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_we, mem_byteEnable, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_we, mem_byteEnable, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store initiator: one request at a time, single-cycle memory access,
// configurable read latency, sign/zero extension and alignment/illegal fault trapping.
module lsu #(
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam logic [CNT_W-1:0] LAT_M1 =
        (MEM_LATENCY == 0) ? '0 : CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic              ready_q, ready_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    logic              req_illegal;
    logic              req_misaligned;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wd;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_data;

    // Request decode: fault classification, lane enables and replicated store data.
    always_comb begin
        if (bus.req_write) begin
            req_illegal = (bus.req_funct3 > 3'd2);
        end else begin
            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                          (bus.req_funct3 == 3'b111);
        end
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_be = 4'b0001 << bus.req_addr[1:0];
                req_wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                req_be = 4'b1111;
                req_wd = bus.req_wdata;
            end
        endcase
    end

    // Load lane extraction from the returned word.
    always_comb begin
        rd_shifted = bus.mem_rd >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_data = rd_shifted;
            3'b100:  load_data = {24'd0, rd_shifted[7:0]};
            3'b101:  load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        mem_we_d     = 1'b0;
        mem_be_d     = '0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    lane_d   = bus.req_addr[1:0];
                    if (req_illegal || req_misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d  = ACCESS;
                        mem_we_d = bus.req_write;
                        mem_be_d = req_be;
                        mem_a_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wd_d = req_wd;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else if (MEM_LATENCY == 0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            lane_q       <= '0;
            ready_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            ready_q      <= ready_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_byteEnable = mem_be_q;
    assign bus.mem_a          = mem_a_q;
    assign bus.mem_wd         = mem_wd_q;

endmodule
